car_scheduler: RTL and testbench
================================

CAR_SCHEDULER -- requirements
Module: car_scheduler

Interface
REQ-001 SHALL have parameter NUM_CARS, default 4, number of car drawer channels served.
REQ-002 SHALL have parameter TIMEOUT, default 4095, max cycles to wait for a channel's finish.
REQ-003 clk  in  1  single system clock; all logic on its rising edge.
REQ-004 resetn  in  1  reset, synchronous, active-low.
REQ-005 go  in  1  frame tick; starts one pass over all channels.
REQ-006 car_en  out  NUM_CARS  one-cycle start pulse per channel.
REQ-007 car_finish  in  NUM_CARS  one-cycle done pulse per channel.
REQ-008 car_plot  in  NUM_CARS  per-channel pixel write strobe.
REQ-009 car_x  in  8*NUM_CARS  per-channel pixel x; channel i at bits [8i+7:8i].
REQ-010 car_y  in  7*NUM_CARS  per-channel pixel y.
REQ-011 car_colour  in  3*NUM_CARS  per-channel pixel colour.
REQ-012 car_x_ori  in  8*NUM_CARS  per-channel car left-edge x.
REQ-013 player_x / player_y  in  8 / 7  player box top-left.
REQ-014 hit_clr  in  1  clears sticky hit.
REQ-015 plot, x, y, colour  out  1/8/7/3  pixel stream to VGA adapter.
REQ-016 frame_done  out  1  one-cycle pulse after last channel finishes.
REQ-017 busy  out  1  high in any state other than IDLE.
REQ-018 hit  out  1  sticky collision flag.
REQ-019 timeout_err  out  1  sticky; set when any channel times out.

Function
REQ-020 FSM states SHALL be IDLE, LAUNCH, WAIT_FIN, NEXT, DONE.
REQ-021 IDLE: go=1 -> LAUNCH with sel=0; else stay.
REQ-022 LAUNCH: car_en[sel]=1 for exactly one cycle, timeout counter cleared; -> WAIT_FIN.
REQ-023 WAIT_FIN: car_finish[sel]=1 -> NEXT; counter==TIMEOUT -> NEXT and set timeout_err; else counter+1.
REQ-024 NEXT: sel==NUM_CARS-1 -> DONE; else sel+1 -> LAUNCH.
REQ-025 DONE: frame_done=1 for one cycle; -> IDLE.
REQ-026 go while not IDLE SHALL be ignored (no queuing).
REQ-027 car_finish from a non-selected channel SHALL be ignored.
REQ-028 Pixel outputs SHALL be registered, 1-cycle latency: plot/x/y/colour equal car_*[sel] of previous cycle while state was LAUNCH or WAIT_FIN; otherwise plot=0.
REQ-029 car_plot of non-selected channels SHALL never reach plot.
REQ-030 car_en SHALL be one-hot or zero at all times.

Reset
REQ-031 resetn=0 at a clock edge: state=IDLE, sel=0, counter=0, car_en=0, plot=0, x=0, y=0, colour=0, frame_done=0, busy=0, hit=0, timeout_err=0.
REQ-032 Reset mid-pass SHALL abort immediately; no frame_done issued.

Configuration
REQ-033 Macro CAR_SCHEDULER_COLLISION_EN: defined -> collision check compiled in; undefined -> hit tied 0, player_x/player_y/hit_clr unused.
REQ-034 With macro: in DONE, for each channel i, overlap of box [car_x_ori_i, +7]x[LANE_Y[i], +3] with [player_x, +7]x[player_y, +3] (9-bit compare, no wrap) SHALL set hit next cycle.
REQ-035 hit_clr=1 clears hit; simultaneous set and clear SHALL leave hit=1.

Structure
REQ-036 Shared package car_pkg SHALL hold CAR_W=8, CAR_H=4, LANE_Y[] table, FSM state encodings.
REQ-037 Sub-module car_overlap (combinational box-overlap test, one instance per channel) SHALL be used.

Verification
REQ-038 go pulse, each channel finishes 10 cycles after its car_en -> car_en pulses in order 0..3, frame_done once, about 4*12 cycles after go.
REQ-039 Channel 2 never finishes, TIMEOUT=15 -> channel 3 launched 17 cycles after channel 2 car_en, timeout_err=1, frame_done still issued.
REQ-040 car_plot=1 on channel 1 while sel=0 -> plot stays 0; channel 0 pixel (x=45,y=45,colour=3'b100) appears on outputs one cycle later.
REQ-041 go asserted in WAIT_FIN -> no extra car_en, single frame_done.
REQ-042 Macro on, LANE_Y[0]=45, car_x_ori[0]=45, player (50,47) -> hit=1 after DONE; player (60,47) -> hit=0; hit_clr -> 0.
REQ-043 resetn low during WAIT_FIN of channel 1 -> next cycle all outputs at reset values, no frame_done.

Source files
------------

// File: rtl/car_pkg.sv
// Shared constants for the car drawer scheduler: geometry, lane table, FSM encodings.
package car_pkg;

    localparam int unsigned X_W    = 8;
    localparam int unsigned Y_W    = 7;
    localparam int unsigned C_W    = 3;
    localparam int unsigned CAR_W  = 8;
    localparam int unsigned CAR_H  = 4;
    localparam int unsigned LANE_N = 8;

    // Top edge of each lane; channel i drives in lane i modulo LANE_N.
    localparam logic [Y_W-1:0] LANE_Y [LANE_N] = '{
        7'd45, 7'd61, 7'd77, 7'd93, 7'd109, 7'd13, 7'd29, 7'd5
    };

    localparam int unsigned ST_W = 3;
    localparam logic [ST_W-1:0] ST_IDLE     = 3'd0;
    localparam logic [ST_W-1:0] ST_LAUNCH   = 3'd1;
    localparam logic [ST_W-1:0] ST_WAIT_FIN = 3'd2;
    localparam logic [ST_W-1:0] ST_NEXT     = 3'd3;
    localparam logic [ST_W-1:0] ST_DONE     = 3'd4;

    typedef struct packed {
        logic           plot;
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [C_W-1:0] colour;
    } pixel_t;

endpackage

// File: rtl/car_scheduler_if.sv
// Bus bundle between the scheduler (slave) and the drawer/VGA side (master).
interface car_scheduler_if
    import car_pkg::*;
#(
    parameter int unsigned NUM_CARS = 4
) ();

    logic                      go;
    logic [NUM_CARS-1:0]       car_en;
    logic [NUM_CARS-1:0]       car_finish;
    logic [NUM_CARS-1:0]       car_plot;
    logic [X_W*NUM_CARS-1:0]   car_x;
    logic [Y_W*NUM_CARS-1:0]   car_y;
    logic [C_W*NUM_CARS-1:0]   car_colour;
    logic [X_W*NUM_CARS-1:0]   car_x_ori;
    logic [X_W-1:0]            player_x;
    logic [Y_W-1:0]            player_y;
    logic                      hit_clr;
    logic                      plot;
    logic [X_W-1:0]            x;
    logic [Y_W-1:0]            y;
    logic [C_W-1:0]            colour;
    logic                      frame_done;
    logic                      busy;
    logic                      hit;
    logic                      timeout_err;

    modport master (
        output go, car_finish, car_plot, car_x, car_y, car_colour, car_x_ori,
               player_x, player_y, hit_clr,
        input  car_en, plot, x, y, colour, frame_done, busy, hit, timeout_err
    );

    modport slave (
        input  go, car_finish, car_plot, car_x, car_y, car_colour, car_x_ori,
               player_x, player_y, hit_clr,
        output car_en, plot, x, y, colour, frame_done, busy, hit, timeout_err
    );

endinterface

// File: rtl/car_overlap.sv
// Combinational overlap test of a car box against the player box (9-bit, no wrap).
module car_overlap
    import car_pkg::*;
(
    input  logic [X_W-1:0] i_ax,
    input  logic [Y_W-1:0] i_ay,
    input  logic [X_W-1:0] i_bx,
    input  logic [Y_W-1:0] i_by,
    output logic           o_hit_c
);

    localparam int unsigned CMP_W = 9;

    logic [CMP_W-1:0] w_ax;
    logic [CMP_W-1:0] w_ay;
    logic [CMP_W-1:0] w_bx;
    logic [CMP_W-1:0] w_by;

    always_comb begin
        w_ax    = CMP_W'(i_ax);
        w_ay    = CMP_W'(i_ay);
        w_bx    = CMP_W'(i_bx);
        w_by    = CMP_W'(i_by);
        o_hit_c = (w_ax <= w_bx + CMP_W'(CAR_W - 1)) &&
                  (w_bx <= w_ax + CMP_W'(CAR_W - 1)) &&
                  (w_ay <= w_by + CMP_W'(CAR_H - 1)) &&
                  (w_by <= w_ay + CMP_W'(CAR_H - 1));
    end

endmodule

// File: rtl/car_scheduler.sv
// Round-robin launcher for NUM_CARS car drawers with pixel muxing and timeout.
// Optional player collision check: define CAR_SCHEDULER_COLLISION_EN.
module car_scheduler
    import car_pkg::*;
#(
    parameter int unsigned NUM_CARS = 4,
    parameter int unsigned TIMEOUT  = 4095
) (
    input  logic           clk,
    input  logic           resetn,
    car_scheduler_if.slave bus
);

    localparam int unsigned SEL_W = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1;
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_CARS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    logic [ST_W-1:0]     r_state;
    logic [ST_W-1:0]     w_next_state;
    logic [SEL_W-1:0]    r_sel;
    logic [SEL_W-1:0]    w_next_sel;
    logic [CNT_W-1:0]    r_cnt;
    logic                w_timeout;
    logic                w_active;
    logic                w_sel_finish;
    pixel_t              w_sel_pix;
    pixel_t              r_pix;
    logic [NUM_CARS-1:0] r_car_en;
    logic                r_frame_done;
    logic                r_busy;
    logic                r_timeout_err;
    logic [NUM_CARS-1:0] w_overlap;

    // Only the selected channel's finish and pixel stream are visible.
    always_comb begin
        w_sel_pix    = '0;
        w_sel_finish = 1'b0;
        for (int i = 0; i < int'(NUM_CARS); i++) begin
            if (r_sel == SEL_W'(i)) begin
                w_sel_finish     = bus.car_finish[i];
                w_sel_pix.plot   = bus.car_plot[i];
                w_sel_pix.x      = bus.car_x[X_W*i +: X_W];
                w_sel_pix.y      = bus.car_y[Y_W*i +: Y_W];
                w_sel_pix.colour = bus.car_colour[C_W*i +: C_W];
            end
        end
    end

    assign w_active = (r_state == ST_LAUNCH) || (r_state == ST_WAIT_FIN);

    always_comb begin
        w_next_state = r_state;
        w_next_sel   = r_sel;
        w_timeout    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.go) begin
                    w_next_state = ST_LAUNCH;
                    w_next_sel   = '0;
                end
            end
            ST_LAUNCH: begin
                w_next_state = ST_WAIT_FIN;
            end
            ST_WAIT_FIN: begin
                if (w_sel_finish) begin
                    w_next_state = ST_NEXT;
                end else if (r_cnt == CNT_MAX) begin
                    w_next_state = ST_NEXT;
                    w_timeout    = 1'b1;
                end
            end
            ST_NEXT: begin
                if (r_sel == LAST_SEL) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_sel   = r_sel + SEL_W'(1);
                    w_next_state = ST_LAUNCH;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_sel   <= '0;
        end else begin
            r_state <= w_next_state;
            r_sel   <= w_next_sel;
        end
    end

    // Status outputs are derived from the next state so they line up with the state itself.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt         <= '0;
            r_car_en      <= '0;
            r_pix         <= '0;
            r_frame_done  <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_car_en <= '0;
            if (w_next_state == ST_LAUNCH) begin
                r_car_en[w_next_sel] <= 1'b1;
            end
            if (w_next_state == ST_LAUNCH) begin
                r_cnt <= '0;
            end else if (w_active) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            r_frame_done <= (w_next_state == ST_DONE);
            r_busy       <= (w_next_state != ST_IDLE);
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
            if (w_active) begin
                r_pix <= w_sel_pix;
            end else begin
                r_pix.plot <= 1'b0;
            end
        end
    end

    for (genvar gi = 0; gi < int'(NUM_CARS); gi++) begin : g_overlap
        car_overlap u_overlap (
            .i_ax    (bus.car_x_ori[X_W*gi +: X_W]),
            .i_ay    (LANE_Y[gi % LANE_N]),
            .i_bx    (bus.player_x),
            .i_by    (bus.player_y),
            .o_hit_c (w_overlap[gi])
        );
    end

`ifdef CAR_SCHEDULER_COLLISION_EN
    logic r_hit;
    logic w_hit_set;

    assign w_hit_set = (r_state == ST_DONE) && (|w_overlap);

    // Set wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_hit <= 1'b0;
        end else if (w_hit_set) begin
            r_hit <= 1'b1;
        end else if (bus.hit_clr) begin
            r_hit <= 1'b0;
        end
    end

    assign bus.hit = r_hit;
`else
    logic w_unused;
    assign w_unused = ^{w_overlap, bus.hit_clr};
    assign bus.hit  = 1'b0;
`endif

    assign bus.car_en      = r_car_en;
    assign bus.plot        = r_pix.plot;
    assign bus.x           = r_pix.x;
    assign bus.y           = r_pix.y;
    assign bus.colour      = r_pix.colour;
    assign bus.frame_done  = r_frame_done;
    assign bus.busy        = r_busy;
    assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_car_scheduler.sv
// Randomized bench for car_scheduler against a launch-schedule model of each pass.
module tb_car_scheduler;
    import car_pkg::*;

    localparam int unsigned NC = 4;
    localparam int          TO = 15;

    logic clk = 1'b0;
    logic resetn;

    car_scheduler_if #(.NUM_CARS(NC)) bus ();

    car_scheduler #(.NUM_CARS(NC), .TIMEOUT(TO)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // Pass description: finish latency per channel (> TO means never finishes).
    int d      [NC];
    int launch [NC+1];
    int fd;
    logic [X_W-1:0] m_ori [NC];
    logic [X_W-1:0] m_px;
    logic [Y_W-1:0] m_py;
    bit exp_te;
    bit exp_hit;

    logic [NC-1:0]     p_plot;
    logic [X_W*NC-1:0] p_x;
    logic [Y_W*NC-1:0] p_y;
    logic [C_W*NC-1:0] p_col;
    bit                p_clr;
    int                p_act;

    function automatic int active_ch(input int c);
        for (int i = 0; i < int'(NC); i++) begin
            if (c >= launch[i] && c <= launch[i] + ((d[i] > TO) ? TO : d[i])) return i;
        end
        return -1;
    endfunction

    function automatic bit model_hit_any();
`ifdef CAR_SCHEDULER_COLLISION_EN
        int ax, ay, bx, by;
        bx = int'(m_px);
        by = int'(m_py);
        for (int i = 0; i < int'(NC); i++) begin
            ax = int'(m_ori[i]);
            ay = int'(LANE_Y[i % LANE_N]);
            if (ax <= bx + 7 && bx <= ax + 7 && ay <= by + 3 && by <= ay + 3) return 1'b1;
        end
`endif
        return 1'b0;
    endfunction

    task automatic apply_static();
        for (int i = 0; i < int'(NC); i++) bus.car_x_ori[X_W*i +: X_W] = m_ori[i];
        bus.player_x = m_px;
        bus.player_y = m_py;
    endtask

    task automatic rand_pixels();
        bus.car_plot = NC'($urandom);
        for (int i = 0; i < int'(NC); i++) begin
            bus.car_x[X_W*i +: X_W]      = X_W'($urandom);
            bus.car_y[Y_W*i +: Y_W]      = Y_W'($urandom);
            bus.car_colour[C_W*i +: C_W] = C_W'($urandom);
        end
    endtask

    // One frame pass; abort_off >= 0 pulls reset that many cycles after channel 1 launches.
    task automatic run_pass(input int abort_off, input bit dir_pix, input bit rand_go, input int clr_mode);
        int g, abort_cyc, c, n;
        bit ab, e_plot;
        logic [NC-1:0] e_en, fin;
        @(negedge clk);
        g = cyc;
        launch[0] = g + 1;
        for (int i = 0; i < int'(NC); i++) launch[i+1] = launch[i] + ((d[i] > TO) ? TO : d[i]) + 2;
        fd = launch[NC];
        abort_cyc = (abort_off < 0) ? -1 : launch[1] + abort_off;
        apply_static();
        resetn = 1'b1;
        bus.go = 1'b1;
        bus.car_finish = '0;
        bus.hit_clr = 1'b0;
        rand_pixels();
        p_plot = bus.car_plot; p_x = bus.car_x; p_y = bus.car_y; p_col = bus.car_colour;
        p_act = -1;
        p_clr = 1'b0;
        n = fd + 3 - g;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            c  = cyc;
            ab = (abort_cyc >= 0) && (c > abort_cyc);
            if (ab) begin
                exp_te  = 1'b0;
                exp_hit = 1'b0;
            end else begin
                for (int i = 0; i < int'(NC); i++) if (d[i] > TO && c == launch[i] + TO + 1) exp_te = 1'b1;
                if (c - 1 == fd && model_hit_any()) exp_hit = 1'b1;
                else if (p_clr) exp_hit = 1'b0;
            end
            e_en = '0;
            if (!ab) for (int i = 0; i < int'(NC); i++) if (launch[i] == c) e_en[i] = 1'b1;
            e_plot = (!ab && p_act >= 0) ? p_plot[p_act] : 1'b0;

            checks++;
            if (bus.car_en !== e_en) begin
                failures++; $display("FAIL car_en cyc=%0d got=%b exp=%b", c, bus.car_en, e_en);
            end
            checks++;
            if (bus.frame_done !== (!ab && c == fd)) begin
                failures++; $display("FAIL frame_done cyc=%0d got=%b exp=%b", c, bus.frame_done, (!ab && c == fd));
            end
            checks++;
            if (bus.busy !== (!ab && c >= launch[0] && c <= fd)) begin
                failures++; $display("FAIL busy cyc=%0d got=%b", c, bus.busy);
            end
            checks++;
            if (bus.plot !== e_plot) begin
                failures++; $display("FAIL plot cyc=%0d got=%b exp=%b", c, bus.plot, e_plot);
            end
            if (ab) begin
                checks++;
                if ({bus.x, bus.y, bus.colour} !== '0) begin
                    failures++; $display("FAIL pix_reset cyc=%0d got x=%0d y=%0d c=%0d exp 0", c, bus.x, bus.y, bus.colour);
                end
            end else if (p_act >= 0) begin
                checks++;
                if (bus.x !== p_x[X_W*p_act +: X_W] || bus.y !== p_y[Y_W*p_act +: Y_W] ||
                    bus.colour !== p_col[C_W*p_act +: C_W]) begin
                    failures++;
                    $display("FAIL pix_data cyc=%0d ch=%0d got x=%0d y=%0d c=%0d exp x=%0d y=%0d c=%0d", c, p_act,
                             bus.x, bus.y, bus.colour, p_x[X_W*p_act +: X_W], p_y[Y_W*p_act +: Y_W],
                             p_col[C_W*p_act +: C_W]);
                end
            end
            checks++;
            if (bus.timeout_err !== exp_te) begin
                failures++; $display("FAIL timeout_err cyc=%0d got=%b exp=%b", c, bus.timeout_err, exp_te);
            end
            checks++;
            if (bus.hit !== exp_hit) begin
                failures++; $display("FAIL hit cyc=%0d got=%b exp=%b", c, bus.hit, exp_hit);
            end

            resetn = (c == abort_cyc) ? 1'b0 : 1'b1;
            bus.go = (rand_go && !ab && c != abort_cyc && c >= launch[0] && c <= fd) ? 1'($urandom_range(1, 0)) : 1'b0;
            fin = '0;
            for (int i = 0; i < int'(NC); i++) begin
                if (d[i] <= TO && c == launch[i] + d[i]) fin[i] = 1'b1;
                else if (active_ch(c) != i && $urandom_range(3, 0) == 0) fin[i] = 1'b1;
            end
            bus.car_finish = fin;
            rand_pixels();
            if (dir_pix) begin
                bus.car_plot[0] = 1'(c % 2);
                bus.car_plot[1] = 1'b1;
                bus.car_x[X_W-1:0] = 8'd45;
                bus.car_y[Y_W-1:0] = 7'd45;
                bus.car_colour[C_W-1:0] = 3'b100;
            end
            if (k == n - 1) bus.hit_clr = 1'b0;
            else if (clr_mode == 2) bus.hit_clr = 1'b1;
            else if (clr_mode == 1) bus.hit_clr = ($urandom_range(7, 0) == 0);
            else bus.hit_clr = 1'b0;
            p_plot = bus.car_plot; p_x = bus.car_x; p_y = bus.car_y; p_col = bus.car_colour;
            p_act = active_ch(c);
            p_clr = bus.hit_clr;
        end
        bus.go = 1'b0;
        bus.car_finish = '0;
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        bus.go = 1'b1;
        bus.hit_clr = 1'b0;
        bus.car_finish = '1;
        rand_pixels();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({bus.car_en, bus.plot, bus.x, bus.y, bus.colour} !== '0) begin
                failures++; $display("FAIL reset_pix got en=%b plot=%b x=%0d y=%0d c=%0d exp 0", bus.car_en, bus.plot, bus.x, bus.y, bus.colour);
            end
            checks++;
            if ({bus.frame_done, bus.busy, bus.hit, bus.timeout_err} !== 4'b0) begin
                failures++; $display("FAIL reset_status got fd=%b busy=%b hit=%b te=%b exp 0", bus.frame_done, bus.busy, bus.hit, bus.timeout_err);
            end
        end
        bus.go = 1'b0;
        bus.car_finish = '0;
        resetn = 1'b1;
        exp_te = 1'b0;
        exp_hit = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.car_en !== '0) begin
            failures++; $display("FAIL idle_after_reset got busy=%b en=%b exp 0", bus.busy, bus.car_en);
        end
    endtask

    task automatic set_all_d(input int v);
        for (int i = 0; i < int'(NC); i++) d[i] = v;
    endtask

    task automatic test_nominal();
        set_all_d(10);
        run_pass(-1, 1'b0, 1'b0, 0);
    endtask

    task automatic test_timeout();
        set_all_d(10);
        d[2] = 100;
        run_pass(-1, 1'b0, 1'b0, 0);
    endtask

    task automatic test_pixel_select();
        set_all_d(10);
        run_pass(-1, 1'b1, 1'b0, 0);
    endtask

    task automatic test_go_during_pass();
        set_all_d(10);
        run_pass(-1, 1'b0, 1'b1, 0);
    endtask

    task automatic test_reset_mid_pass();
        set_all_d(10);
        run_pass(3, 1'b0, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < int'(NC); i++) d[i] = $urandom_range(4, 1);
            run_pass(-1, 1'b0, 1'b0, 1);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < int'(NC); i++) begin
                d[i]     = $urandom_range(20, 1);
                m_ori[i] = X_W'($urandom_range(70, 30));
            end
            m_px = X_W'($urandom_range(70, 30));
            m_py = Y_W'($urandom_range(100, 40));
            run_pass((r % 7 == 6) ? int'($urandom_range(8, 0)) : -1, 1'($urandom_range(1, 0)),
                     1'($urandom_range(1, 0)), int'($urandom_range(2, 0)));
        end
    endtask

`ifdef CAR_SCHEDULER_COLLISION_EN
    task automatic test_collision();
        set_all_d(10);
        m_ori[0] = 8'd45;
        for (int i = 1; i < int'(NC); i++) m_ori[i] = 8'd200;
        m_px = 8'd50;
        m_py = 7'd47;
        run_pass(-1, 1'b0, 1'b0, 0);
        @(negedge clk);
        checks++;
        if (bus.hit !== 1'b1) begin
            failures++; $display("FAIL hit_overlap got=%b exp=1", bus.hit);
        end
        bus.hit_clr = 1'b1;
        @(negedge clk);
        bus.hit_clr = 1'b0;
        exp_hit = 1'b0;
        checks++;
        if (bus.hit !== 1'b0) begin
            failures++; $display("FAIL hit_clear got=%b exp=0", bus.hit);
        end
        m_px = 8'd60;
        run_pass(-1, 1'b0, 1'b0, 0);
        @(negedge clk);
        checks++;
        if (bus.hit !== 1'b0) begin
            failures++; $display("FAIL hit_no_overlap got=%b exp=0", bus.hit);
        end
        m_px = 8'd50;
        run_pass(-1, 1'b0, 1'b0, 2);
    endtask
`endif

    initial begin
        resetn = 1'b0;
        bus.go = 1'b0;
        bus.car_finish = '0;
        bus.car_plot = '0;
        bus.car_x = '0;
        bus.car_y = '0;
        bus.car_colour = '0;
        bus.car_x_ori = '0;
        bus.player_x = '0;
        bus.player_y = '0;
        bus.hit_clr = 1'b0;
        for (int i = 0; i < int'(NC); i++) m_ori[i] = 8'd200;
        m_px = 8'd0;
        m_py = 7'd0;
        exp_te = 1'b0;
        exp_hit = 1'b0;

        test_reset();
        test_nominal();
        test_timeout();
        test_pixel_select();
        test_go_during_pass();
        test_reset_mid_pass();
        test_back_to_back();
        test_random();
`ifdef CAR_SCHEDULER_COLLISION_EN
        test_collision();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
